// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution.
// Holds one executed instruction toward the memory stage and forms its write-back
// value. Resolves control transfers into a one-cycle redirect/flush pulse and keeps
// saturating branch statistics.
module ex_mem_stage #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  // Execute side
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_alu_result,
  input  logic             ex_br_taken_n,
  input  logic             ex_is_branch,
  input  logic             ex_is_jal,
  input  logic             ex_is_jalr,
  input  logic             ex_mem_rd,
  input  logic             ex_mem_wr,
  input  logic             ex_reg_wr,
  input  logic [4:0]       ex_rd,
  input  logic [XLEN-1:0]  ex_store_data,
  // Memory side
  output logic             mem_valid,
  input  logic             mem_ready,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wb_data,
  output logic [XLEN-1:0]  mem_store_data,
  output logic             mem_rd_en,
  output logic             mem_wr_en,
  output logic             mem_reg_wr,
  output logic [4:0]       mem_rd,
  output logic             mem_misalign,
  // Fetch/decode control
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  // Statistics
  output logic [CNT_W-1:0] br_total_cnt,
  output logic [CNT_W-1:0] br_taken_cnt
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic            accept;
  logic            is_jalr, is_jal, is_br, is_cti, taken;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] wb_data;
  logic            misalign;
  logic            redirect_new;

  logic [XLEN-1:0] addr_q, wb_data_q, store_data_q, redirect_pc_q;
  logic            rd_en_q, wr_en_q, reg_wr_q, misalign_q;
  logic [4:0]      rd_q;
  logic            redirect_q;

  logic [CNT_W-1:0] total_q, total_d, taken_q, taken_d;

  // Handshake: no acceptance while a redirect is in flight (that slot is wrong-path).
  assign mem_valid = (state_q == StFull);
  assign ex_ready  = ~redirect_q & (~mem_valid | mem_ready);
  assign accept    = ex_valid & ex_ready;

  // Control-transfer decode with jalr > jal > branch priority, target and link.
  always_comb begin
    is_jalr      = ex_is_jalr;
    is_jal       = ex_is_jal & ~ex_is_jalr;
    is_br        = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
    is_cti       = is_jalr | is_jal | is_br;
    taken        = is_jalr | is_jal | (is_br & ~ex_br_taken_n);
    target       = is_jalr ? {ex_alu_result[XLEN-1:1], 1'b0} : (ex_pc + ex_imm);
    wb_data      = (is_jalr | is_jal) ? (ex_pc + XLEN'(4)) : ex_alu_result;
    // Misaligned targets trap downstream instead of redirecting.
    misalign     = taken & target[1];
    redirect_new = taken & ~target[1];
  end

  // Entry occupancy next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StFull;
      StFull:  if (mem_ready && !accept) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  // Entry occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StEmpty;
    else        state_q <= state_d;
  end

  // Entry payload: loaded on accept, otherwise held stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q       <= '0;
      wb_data_q    <= '0;
      store_data_q <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      reg_wr_q     <= 1'b0;
      rd_q         <= '0;
      misalign_q   <= 1'b0;
    end else if (accept) begin
      addr_q       <= ex_alu_result;
      wb_data_q    <= wb_data;
      store_data_q <= ex_store_data;
      rd_en_q      <= ex_mem_rd;
      wr_en_q      <= ex_mem_wr;
      reg_wr_q     <= ex_reg_wr & ~misalign;
      rd_q         <= ex_rd;
      misalign_q   <= misalign;
    end
  end

  // Redirect pulse lasts exactly the cycle after accept, independent of mem_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= accept & redirect_new;
      if (accept && redirect_new) redirect_pc_q <= target;
    end
  end

  // Saturating statistics next-state.
  always_comb begin
    total_d = total_q;
    taken_d = taken_q;
    if (accept && is_cti && (total_q != '1)) total_d = total_q + CNT_W'(1);
    if (accept && taken  && (taken_q != '1)) taken_d = taken_q + CNT_W'(1);
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      total_q <= '0;
      taken_q <= '0;
    end else begin
      total_q <= total_d;
      taken_q <= taken_d;
    end
  end

  assign mem_addr       = addr_q;
  assign mem_wb_data    = wb_data_q;
  assign mem_store_data = store_data_q;
  assign mem_rd_en      = rd_en_q;
  assign mem_wr_en      = wr_en_q;
  assign mem_reg_wr     = reg_wr_q;
  assign mem_rd         = rd_q;
  assign mem_misalign   = misalign_q;
  assign redirect_valid = redirect_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = redirect_q;
  assign br_total_cnt   = total_q;
  assign br_taken_cnt   = taken_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: each accepted instruction pushes its expected
// entry; the entry is compared every cycle it is presented and popped on drain.
module tb_ex_mem_stage;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 2;
  localparam logic [63:0] CntMax = 64'd3;

  logic             clk, rst_n;
  logic             ex_valid, ex_ready;
  logic [XLEN-1:0]  ex_pc, ex_imm, ex_alu_result, ex_store_data;
  logic             ex_br_taken_n, ex_is_branch, ex_is_jal, ex_is_jalr;
  logic             ex_mem_rd, ex_mem_wr, ex_reg_wr;
  logic [4:0]       ex_rd;
  logic             mem_valid, mem_ready;
  logic [XLEN-1:0]  mem_addr, mem_wb_data, mem_store_data;
  logic             mem_rd_en, mem_wr_en, mem_reg_wr, mem_misalign;
  logic [4:0]       mem_rd;
  logic             redirect_valid, flush;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] br_total_cnt, br_taken_cnt;

  ex_mem_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ex_valid       (ex_valid),
    .ex_ready       (ex_ready),
    .ex_pc          (ex_pc),
    .ex_imm         (ex_imm),
    .ex_alu_result  (ex_alu_result),
    .ex_br_taken_n  (ex_br_taken_n),
    .ex_is_branch   (ex_is_branch),
    .ex_is_jal      (ex_is_jal),
    .ex_is_jalr     (ex_is_jalr),
    .ex_mem_rd      (ex_mem_rd),
    .ex_mem_wr      (ex_mem_wr),
    .ex_reg_wr      (ex_reg_wr),
    .ex_rd          (ex_rd),
    .ex_store_data  (ex_store_data),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_addr       (mem_addr),
    .mem_wb_data    (mem_wb_data),
    .mem_store_data (mem_store_data),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .mem_reg_wr     (mem_reg_wr),
    .mem_rd         (mem_rd),
    .mem_misalign   (mem_misalign),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush),
    .br_total_cnt   (br_total_cnt),
    .br_taken_cnt   (br_taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wb;
    logic [63:0] sd;
    logic        rd_en;
    logic        wr_en;
    logic        reg_wr;
    logic [4:0]  rd;
    logic        mis;
  } entry_t;

  entry_t      q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  logic        mon_en   = 1'b0;
  logic        acc      = 1'b0;
  logic        m_redir  = 1'b0;
  logic [63:0] m_rpc    = '0;
  logic [63:0] m_tot    = '0;
  logic [63:0] m_tkn    = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle while inputs are stable.
  always @(negedge clk) begin
    logic        exp_ready, jr, jl, br, tk, mis;
    logic [63:0] tgt;
    entry_t      e;
    if (!mon_en) begin
      q.delete();
      m_redir = 1'b0;
      m_rpc   = '0;
      m_tot   = '0;
      m_tkn   = '0;
      acc     = 1'b0;
    end else begin
      exp_ready = !m_redir && (q.size() == 0 || mem_ready);
      check_eq("ex_ready", ex_ready, exp_ready);
      check_eq("mem_valid", mem_valid, q.size() != 0);
      check_eq("redirect_valid", redirect_valid, m_redir);
      check_eq("flush", flush, m_redir);
      if (m_redir) check_eq("redirect_pc", redirect_pc, m_rpc);
      check_eq("br_total_cnt", br_total_cnt, m_tot);
      check_eq("br_taken_cnt", br_taken_cnt, m_tkn);
      if (q.size() != 0) begin
        e = q[0];
        check_eq("mem_addr", mem_addr, e.addr);
        check_eq("mem_wb_data", mem_wb_data, e.wb);
        check_eq("mem_store_data", mem_store_data, e.sd);
        check_eq("mem_rd_en", mem_rd_en, e.rd_en);
        check_eq("mem_wr_en", mem_wr_en, e.wr_en);
        check_eq("mem_reg_wr", mem_reg_wr, e.reg_wr);
        check_eq("mem_rd", mem_rd, e.rd);
        check_eq("mem_misalign", mem_misalign, e.mis);
        if (mem_ready) void'(q.pop_front());
      end
      acc     = ex_valid && exp_ready;
      m_redir = 1'b0;
      if (acc) begin
        jr  = ex_is_jalr;
        jl  = ex_is_jal && !jr;
        br  = ex_is_branch && !jr && !jl;
        tk  = jr || jl || (br && !ex_br_taken_n);
        tgt = jr ? (ex_alu_result & 64'hFFFF_FFFF_FFFF_FFFE) : (ex_pc + ex_imm);
        mis = tk && tgt[1];
        e.addr   = ex_alu_result;
        e.wb     = (jr || jl) ? ex_pc + 64'd4 : ex_alu_result;
        e.sd     = ex_store_data;
        e.rd_en  = ex_mem_rd;
        e.wr_en  = ex_mem_wr;
        e.reg_wr = ex_reg_wr && !mis;
        e.rd     = ex_rd;
        e.mis    = mis;
        q.push_back(e);
        if ((jr || jl || br) && m_tot != CntMax) m_tot = m_tot + 64'd1;
        if (tk && m_tkn != CntMax) m_tkn = m_tkn + 64'd1;
        if (tk && !mis) begin
          m_redir = 1'b1;
          m_rpc   = tgt;
        end
      end
    end
  end

  // Present one instruction and hold it until the stage accepts it.
  task automatic send(input logic [63:0] pc, input logic [63:0] imm, input logic [63:0] alu,
                      input logic btn, input logic br, input logic jal, input logic jalr,
                      input logic mrd, input logic mwr, input logic rw, input logic [4:0] rd,
                      input logic [63:0] sd);
    ex_pc = pc; ex_imm = imm; ex_alu_result = alu; ex_br_taken_n = btn;
    ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
    ex_mem_rd = mrd; ex_mem_wr = mwr; ex_reg_wr = rw; ex_rd = rd; ex_store_data = sd;
    ex_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      if (acc) break;
    end
    check_eq("accept", acc, 1'b1);
    #1;
    ex_valid = 1'b0;
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_mem_valid", mem_valid, 0);
    check_eq("rst_redirect_valid", redirect_valid, 0);
    check_eq("rst_flush", flush, 0);
    check_eq("rst_mem_misalign", mem_misalign, 0);
    check_eq("rst_enables", {mem_rd_en, mem_wr_en, mem_reg_wr}, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wb_data", mem_wb_data, 0);
    check_eq("rst_mem_store_data", mem_store_data, 0);
    check_eq("rst_mem_rd", mem_rd, 0);
    check_eq("rst_redirect_pc", redirect_pc, 0);
    check_eq("rst_counters", {br_total_cnt, br_taken_cnt}, 0);
    check_eq("rst_ex_ready", ex_ready, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; mem_ready = 1'b1; ex_valid = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_alu_result = '0; ex_br_taken_n = 1'b1;
    ex_is_branch = 1'b0; ex_is_jal = 1'b0; ex_is_jalr = 1'b0;
    ex_mem_rd = 1'b0; ex_mem_wr = 1'b0; ex_reg_wr = 1'b0; ex_rd = '0; ex_store_data = '0;
    #1 check_reset_outputs();
    idle(3);
    rst_n = 1'b1; mon_en = 1'b1;

    // ALU add, BEQ taken/not-taken, JAL link
    send(64'h0, 64'h0, 64'h1000, 1, 0, 0, 0, 0, 0, 1, 5'd5, 64'h0);
    send(64'h200, -64'sd16, 64'h0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 64'h0);
    send(64'h204, 64'h40, 64'h0, 1, 1, 0, 0, 0, 0, 0, 5'd0, 64'h0);
    send(64'h100, 64'h40, 64'h77, 1, 0, 1, 0, 0, 0, 1, 5'd1, 64'h0);
    // JALR misaligned, then aligned; all flags set exercises priority
    send(64'h400, 64'h0, 64'h3003, 1, 0, 0, 1, 0, 0, 1, 5'd2, 64'h0);
    send(64'h404, 64'h8, 64'h3001, 0, 1, 1, 1, 0, 0, 1, 5'd3, 64'h0);
    idle(2);

    // Stall for three cycles with the next instruction waiting, then back-to-back
    mem_ready = 1'b0;
    send(64'h0, 64'h0, 64'h2000, 1, 0, 0, 0, 0, 1, 0, 5'd0, 64'hDEAD_BEEF);
    fork
      send(64'h0, 64'h0, 64'h2008, 1, 0, 0, 0, 1, 0, 1, 5'd9, 64'h0);
      begin
        idle(3);
        mem_ready = 1'b1;
      end
    join
    send(64'h0, 64'h0, 64'h2010, 1, 0, 0, 0, 1, 0, 1, 5'd10, 64'h0);

    // More taken branches keep both counters pinned at their maximum
    send(64'h800, 64'h10, 64'h0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 64'h0);
    send(64'h900, 64'h20, 64'h0, 0, 1, 0, 0, 0, 0, 0, 5'd0, 64'h0);
    idle(2);

    // Reset while a redirect is live and the entry is stalled
    mem_ready = 1'b0;
    send(64'h500, 64'h20, 64'h0, 1, 0, 1, 0, 0, 0, 1, 5'd4, 64'h0);
    #2 rst_n = 1'b0; mon_en = 1'b0;
    #1 check_reset_outputs();
    idle(2);
    rst_n = 1'b1; mon_en = 1'b1; mem_ready = 1'b1;
    send(64'h0, 64'h0, 64'h1234, 1, 0, 0, 0, 0, 0, 1, 5'd7, 64'h0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
